io_pad_ctrl: RTL and testbench
==============================

// Module: io_pad_ctrl
// PURPOSE
//  Pin-side stage directly downstream of the TRIS register block. Holds the PORTA/B/C output
//  data latches and drives pin outputs and output-enables from them and the incoming TRIS values.
//  Synchronizes asynchronous pin inputs and returns them as read data for file-register reads
//  of 0x05..0x07. Keeps a sticky port-B change flag for polling firmware.
// PARAMETERS
//  A_WIDTH      4  PORTA width (bits)
//  B_WIDTH      8  PORTB width
//  C_WIDTH      8  PORTC width
//  SYNC_STAGES  2  input synchronizer depth, >=2
// PORTS
//  clk        in   1        core clock; only clock in block
//  rst        in   1        synchronous reset, active-high
//  trisAReg   in   A_WIDTH  TRIS A from port block; 1=input, 0=output
//  trisBReg   in   B_WIDTH  TRIS B
//  trisCReg   in   C_WIDTH  TRIS C
//  wrEn       in   1        one-cycle file-register write strobe
//  wrAddr     in   5        file-register write address
//  wrData     in   8        write data (W or ALU result)
//  rdAddr     in   5        file-register read address
//  rdData     out  8        port read data, 0 when rdAddr not a port
//  pinAIn     in   A_WIDTH  raw pad inputs, asynchronous
//  pinBIn     in   B_WIDTH
//  pinCIn     in   C_WIDTH
//  pinAOut    out  A_WIDTH  pad output values = data latch A
//  pinBOut    out  B_WIDTH
//  pinCOut    out  C_WIDTH
//  pinAOe     out  A_WIDTH  pad output enable = ~trisAReg
//  pinBOe     out  B_WIDTH
//  pinCOe     out  C_WIDTH
//  rbChange   out  1        sticky: port-B input pin differs from last-read snapshot
// BEHAVIOUR
//  Reset (rst=1 at posedge): latches A/B/C=0, all sync stages=0, B snapshot=0, rbChange=0.
//   Oe follows TRIS combinationally, so all pads are inputs while TRIS holds its reset value.
//  Writes: wrEn && wrAddr==5/6/7 loads latch A/B/C at that posedge. A takes wrData[A_WIDTH-1:0].
//   The pinXOut change is visible the cycle after the strobe. Other addresses are ignored.
//   Latches are written regardless of TRIS; value is driven once TRIS bit clears.
//  Sync: each pin bit passes SYNC_STAGES flops. A pad edge is visible on rdData after
//   SYNC_STAGES posedges. No filtering; metastability only handled by depth.
//  Read: combinational mux of last sync stage (the pin, not the latch, for all bits incl. outputs):
//   rdAddr 5 -> {zero-pad, syncA}; 6 -> syncB; 7 -> syncC; else 8'h00.
//   Loopback: an output bit written at cycle N reads back at N+1+SYNC_STAGES.
//  Read and write of the same port in one cycle: rdData = synchronized pin (old value);
//   latch updates at the edge.
//  rbChange: "read of PORTB" = rdEn-free decode, rdAddr==6 && a one-cycle rdStb
//   is not used; snapshot loads syncB on every cycle rdAddr==6.
//   Each cycle: mismatch = |((syncB ^ snapB) & trisBReg). Set when mismatch && rdAddr!=6.
//   Cleared (and snapshot loaded) when rdAddr==6. Set and clear in the same cycle -> clear wins.
//   New data is captured by the snapshot, so no change is lost.
//   Output-mode bits (TRIS=0) never set the flag.
//  Reset mid-operation: latches and flags return to reset values at the next edge.
//   Pin outputs go to 0; oe still follows the TRIS inputs.
// TESTING
//  Reset, TRIS=all-1 -> all Oe=0, all Out=0, rdData=0 for rdAddr 5/6/7 with pins low, rbChange=0.
//  trisB=8'h00, wrEn wrAddr=6 wrData=8'hA5 -> pinBOut=A5, pinBOe=FF next cycle; pins looped back;
//   rdAddr=6 gives A5 exactly 1+SYNC_STAGES cycles after the strobe.
//  wrAddr=5 wrData=8'hFF, trisA=4'h0 -> pinAOut=4'hF. rdAddr=5 with pinAIn=4'hF -> rdData=8'h0F.
//  trisB=FF, rdAddr=6 once, then pinBIn bit3 rises -> rbChange=1 at SYNC_STAGES+1 edges.
//   rdAddr=6 -> rbChange=0 next cycle and stays 0.
//  Same-cycle wrAddr=7 and rdAddr=7 with pinCIn=8'h3C, wrData=8'hC3 -> rdData=3C that cycle,
//   pinCOut=C3 next.
//  rst asserted one cycle after a PORTC write -> pinCOut=0, rbChange=0 after that edge.

Source files
------------

// File: rtl/io_pad_ctrl.sv
// Pin-side port stage: PORTA/B/C output latches, pad drive/enable, input
// synchronizers, port read mux and a sticky port-B change flag.

module io_port_lane #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] lat_o,
  output logic [W-1:0] sync_o
);
  logic [W-1:0]                  lat_q, lat_d;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;

  always_comb begin
    lat_d = lat_q;
    if (we_i) lat_d = wdata_i;
  end

  // Stage 0 samples the raw pad; the top stage is the only one consumed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_q  <= '0;
      sync_q <= '0;
    end else begin
      lat_q  <= lat_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign lat_o  = lat_q;
  assign sync_o = sync_q[SYNC_STAGES-1];
endmodule

module io_pad_ctrl #(
  parameter int A_WIDTH     = 4,
  parameter int B_WIDTH     = 8,
  parameter int C_WIDTH     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] trisAReg,
  input  logic [B_WIDTH-1:0] trisBReg,
  input  logic [C_WIDTH-1:0] trisCReg,
  input  logic               wrEn,
  input  logic [4:0]         wrAddr,
  input  logic [7:0]         wrData,
  input  logic [4:0]         rdAddr,
  output logic [7:0]         rdData,
  input  logic [A_WIDTH-1:0] pinAIn,
  input  logic [B_WIDTH-1:0] pinBIn,
  input  logic [C_WIDTH-1:0] pinCIn,
  output logic [A_WIDTH-1:0] pinAOut,
  output logic [B_WIDTH-1:0] pinBOut,
  output logic [C_WIDTH-1:0] pinCOut,
  output logic [A_WIDTH-1:0] pinAOe,
  output logic [B_WIDTH-1:0] pinBOe,
  output logic [C_WIDTH-1:0] pinCOe,
  output logic               rbChange
);
  localparam logic [4:0] ADDR_A = 5'd5;
  localparam logic [4:0] ADDR_B = 5'd6;
  localparam logic [4:0] ADDR_C = 5'd7;

  logic [A_WIDTH-1:0] sync_a;
  logic [B_WIDTH-1:0] sync_b;
  logic [C_WIDTH-1:0] sync_c;
  logic               we_a, we_b, we_c;

  assign we_a = wrEn && (wrAddr == ADDR_A);
  assign we_b = wrEn && (wrAddr == ADDR_B);
  assign we_c = wrEn && (wrAddr == ADDR_C);

  io_port_lane #(.W(A_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_port_a (
    .clk_i(clk), .rst_i(rst), .we_i(we_a), .wdata_i(wrData[A_WIDTH-1:0]),
    .pin_i(pinAIn), .lat_o(pinAOut), .sync_o(sync_a)
  );
  io_port_lane #(.W(B_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_port_b (
    .clk_i(clk), .rst_i(rst), .we_i(we_b), .wdata_i(wrData[B_WIDTH-1:0]),
    .pin_i(pinBIn), .lat_o(pinBOut), .sync_o(sync_b)
  );
  io_port_lane #(.W(C_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_port_c (
    .clk_i(clk), .rst_i(rst), .we_i(we_c), .wdata_i(wrData[C_WIDTH-1:0]),
    .pin_i(pinCIn), .lat_o(pinCOut), .sync_o(sync_c)
  );

  // Output enable tracks TRIS directly, independent of reset.
  assign pinAOe = ~trisAReg;
  assign pinBOe = ~trisBReg;
  assign pinCOe = ~trisCReg;

  // Reads always return the synchronized pad, never the latch.
  logic [7:0] rd_a, rd_b, rd_c;
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    rd_c = '0;
    rd_a[A_WIDTH-1:0] = sync_a;
    rd_b[B_WIDTH-1:0] = sync_b;
    rd_c[C_WIDTH-1:0] = sync_c;
    case (rdAddr)
      ADDR_A:  rdData = rd_a;
      ADDR_B:  rdData = rd_b;
      ADDR_C:  rdData = rd_c;
      default: rdData = 8'h00;
    endcase
  end

  // Sticky change flag: a PORTB read re-arms the snapshot and wins over set.
  logic [B_WIDTH-1:0] snap_q, snap_d;
  logic               rb_q, rb_d;
  logic               rd_b_hit, mismatch;

  assign rd_b_hit = (rdAddr == ADDR_B);
  assign mismatch = |((sync_b ^ snap_q) & trisBReg);

  always_comb begin
    snap_d = snap_q;
    rb_d   = rb_q;
    if (rd_b_hit) begin
      snap_d = sync_b;
      rb_d   = 1'b0;
    end else if (mismatch) begin
      rb_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
      rb_q   <= 1'b0;
    end else begin
      snap_q <= snap_d;
      rb_q   <= rb_d;
    end
  end

  assign rbChange = rb_q;
endmodule

// File: tb/tb_io_pad_ctrl.sv
// Self-checking bench: directed vector table, hand sequences for the change
// flag and mid-run reset, then random traffic against a history-based model.

module tb_io_pad_ctrl;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] trisA;
  logic [7:0] trisB, trisC;
  logic       wrEn;
  logic [4:0] wrAddr, rdAddr;
  logic [7:0] wrData, rdData;
  logic [3:0] pinA, aOut, aOe;
  logic [7:0] pinB, pinC, bOut, cOut, bOe, cOe;
  logic       rbChange;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  io_pad_ctrl #(.A_WIDTH(4), .B_WIDTH(8), .C_WIDTH(8), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .trisAReg(trisA), .trisBReg(trisB), .trisCReg(trisC),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .rdAddr(rdAddr), .rdData(rdData),
    .pinAIn(pinA), .pinBIn(pinB), .pinCIn(pinC),
    .pinAOut(aOut), .pinBOut(bOut), .pinCOut(cOut),
    .pinAOe(aOe), .pinBOe(bOe), .pinCOe(cOe), .rbChange(rbChange)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] ta, input logic [7:0] tb, input logic [7:0] tc,
                       input logic we, input logic [4:0] wa, input logic [7:0] wd, input logic [4:0] ra,
                       input logic [3:0] pa, input logic [7:0] pb, input logic [7:0] pc);
    rst = r; trisA = ta; trisB = tb; trisC = tc;
    wrEn = we; wrAddr = wa; wrData = wd; rdAddr = ra;
    pinA = pa; pinB = pb; pinC = pc;
  endtask

  typedef struct {
    logic       r;
    logic [3:0] ta;
    logic [7:0] tb, tc;
    logic       we;
    logic [4:0] wa;
    logic [7:0] wd;
    logic [4:0] ra;
    logic [3:0] pa;
    logic [7:0] pb, pc;
    logic [7:0] e_rd;
    logic [3:0] e_ao;
    logic [7:0] e_bo, e_co;
    logic       e_rb;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] ta, logic [7:0] tb, logic [7:0] tc,
                              logic we, logic [4:0] wa, logic [7:0] wd, logic [4:0] ra,
                              logic [3:0] pa, logic [7:0] pb, logic [7:0] pc,
                              logic [7:0] e_rd, logic [3:0] e_ao, logic [7:0] e_bo,
                              logic [7:0] e_co, logic e_rb);
    vec_t v;
    v.r = r; v.ta = ta; v.tb = tb; v.tc = tc; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
    v.pa = pa; v.pb = pb; v.pc = pc; v.e_rd = e_rd; v.e_ao = e_ao; v.e_bo = e_bo;
    v.e_co = e_co; v.e_rb = e_rb;
    return v;
  endfunction

  // Reference model: pad history queue plus port-level state.
  logic [3:0] m_la;
  logic [7:0] m_lb, m_lc, m_snap;
  logic       m_rb;
  logic [19:0] hist[$];

  function automatic logic [19:0] m_sync();
    return hist[SS-1];
  endfunction

  function automatic logic [7:0] m_rd(input logic [4:0] ra);
    logic [19:0] s;
    s = m_sync();
    case (ra)
      5'd5:    return {4'h0, s[19:16]};
      5'd6:    return s[15:8];
      5'd7:    return s[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_la = '0; m_lb = '0; m_lc = '0; m_snap = '0; m_rb = 1'b0;
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(20'h0);
  endtask

  task automatic m_edge();
    logic [7:0] sb;
    if (rst) begin
      m_reset();
    end else begin
      sb = m_sync() >> 8;
      if (wrEn && wrAddr == 5'd5) m_la = wrData[3:0];
      if (wrEn && wrAddr == 5'd6) m_lb = wrData;
      if (wrEn && wrAddr == 5'd7) m_lc = wrData;
      if (rdAddr == 5'd6) begin
        m_snap = sb;
        m_rb   = 1'b0;
      end else if (((sb ^ m_snap) & trisB) != 0) begin
        m_rb = 1'b1;
      end
      hist.push_front({pinA, pinB, pinC});
      void'(hist.pop_back());
    end
  endtask

  vec_t vt[$];

  initial begin
    drive(1, 4'hF, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    vt.push_back(mk(1, 4'hF, 8'hFF, 8'hFF, 0, 0, 8'h00, 5, 0, 0, 0,    8'h00, 0, 8'h00, 8'h00, 0));
    vt.push_back(mk(0, 4'hF, 8'hFF, 8'hFF, 0, 0, 8'h00, 6, 0, 0, 0,    8'h00, 0, 8'h00, 8'h00, 0));
    vt.push_back(mk(0, 4'hF, 8'hFF, 8'hFF, 0, 0, 8'h00, 7, 0, 0, 0,    8'h00, 0, 8'h00, 8'h00, 0));
    vt.push_back(mk(0, 4'hF, 8'h00, 8'hFF, 1, 6, 8'hA5, 0, 0, 0, 0,    8'h00, 0, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'hF, 8'h00, 8'hFF, 0, 0, 8'h00, 6, 0, 8'hA5, 0, 8'h00, 0, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'hF, 8'h00, 8'hFF, 0, 0, 8'h00, 6, 0, 8'hA5, 0, 8'h00, 0, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'hF, 8'h00, 8'hFF, 0, 0, 8'h00, 6, 0, 8'hA5, 0, 8'hA5, 0, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'h0, 8'h00, 8'hFF, 1, 5, 8'hFF, 6, 4'hF, 8'hA5, 0, 8'hA5, 4'hF, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'h0, 8'h00, 8'hFF, 0, 0, 8'h00, 5, 4'hF, 8'hA5, 0, 8'h00, 4'hF, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'h0, 8'h00, 8'hFF, 0, 0, 8'h00, 5, 4'hF, 8'hA5, 0, 8'h0F, 4'hF, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'h0, 8'h00, 8'hFF, 0, 0, 8'h00, 7, 4'hF, 8'hA5, 8'h3C, 8'h00, 4'hF, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'h0, 8'h00, 8'hFF, 0, 0, 8'h00, 7, 4'hF, 8'hA5, 8'h3C, 8'h00, 4'hF, 8'hA5, 8'h00, 0));
    vt.push_back(mk(0, 4'h0, 8'h00, 8'hFF, 1, 7, 8'hC3, 7, 4'hF, 8'hA5, 8'h3C, 8'h3C, 4'hF, 8'hA5, 8'hC3, 0));
    vt.push_back(mk(0, 4'h0, 8'h00, 8'hFF, 1, 3, 8'h00, 8, 4'hF, 8'hA5, 8'h3C, 8'h00, 4'hF, 8'hA5, 8'hC3, 0));

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].ta, vt[i].tb, vt[i].tc, vt[i].we, vt[i].wa, vt[i].wd, vt[i].ra,
            vt[i].pa, vt[i].pb, vt[i].pc);
      #1;
      chk($sformatf("vec%0d rdData", i), rdData, vt[i].e_rd);
      chk($sformatf("vec%0d oe", i), {aOe, bOe, cOe}, {~vt[i].ta, ~vt[i].tb, ~vt[i].tc});
      tick();
      chk($sformatf("vec%0d outs", i), {aOut, bOut, cOut}, {vt[i].e_ao, vt[i].e_bo, vt[i].e_co});
      chk($sformatf("vec%0d rb", i), rbChange, vt[i].e_rb);
    end

    // Port-B change flag timing and clear.
    drive(1, 4'hF, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 0; rdAddr = 6; tick();
    rdAddr = 0; pinB = 8'h08;
    tick(); chk("rb edge1", rbChange, 0);
    tick(); chk("rb edge2", rbChange, 0);
    tick(); chk("rb edge3", rbChange, 1);
    tick(); chk("rb sticky", rbChange, 1);
    rdAddr = 6; tick(); chk("rb clear", rbChange, 0);
    rdAddr = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("rb stays0 %0d", i), rbChange, 0);
    end
    trisB = 8'h00; pinB = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    chk("rb output-bit ignored", rbChange, 0);

    // Reset one cycle after a PORTC write, with the flag set.
    trisB = 8'hFF; pinB = 8'hF0;
    for (int i = 0; i < 3; i++) tick();
    chk("rb set pre-reset", rbChange, 1);
    wrEn = 1; wrAddr = 7; wrData = 8'h55; tick();
    chk("C write", cOut, 8'h55);
    wrEn = 0; rst = 1; trisC = 8'h0F; #1;
    chk("oe in reset", cOe, 8'hF0);
    tick();
    chk("C after rst", cOut, 8'h00);
    chk("rb after rst", rbChange, 0);

    // Randomized traffic against the model.
    drive(1, 4'hF, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    m_reset();
    pinB = 8'h00;
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 39) == 0);
      trisA  = 4'($urandom);
      trisB  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      trisC  = 8'($urandom);
      wrEn   = $urandom_range(0, 1);
      wrAddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(5 + $urandom_range(0, 2));
      wrData = 8'($urandom);
      rdAddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(5 + $urandom_range(0, 2));
      pinA   = 4'($urandom);
      if ($urandom_range(0, 3) == 0) pinB = pinB ^ (8'h1 << $urandom_range(0, 7));
      pinC   = 8'($urandom);
      #1;
      chk("rnd rdData", rdData, m_rd(rdAddr));
      chk("rnd oe", {aOe, bOe, cOe}, {~trisA, ~trisB, ~trisC});
      m_edge();
      tick();
      chk("rnd outs", {aOut, bOut, cOut}, {m_la, m_lb, m_lc});
      chk("rnd rb", rbChange, m_rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
